// File: rtl/err_metric_accum.sv
// Streaming error-statistics accumulator for an approximate/exact multiplier pair.
// Gathers the terms needed for NMED plus peak error and nonzero-error count.
module err_metric_accum #(
  parameter int PW    = 16,
  parameter int CNT_W = 17,
  parameter int ACC_W = 34
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic signed [PW-1:0] prod_approx,
  input  logic signed [PW-1:0] prod_exact,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_W-1:0]     sum_abs_err,
  output logic [PW:0]          max_abs_err,
  output logic signed [PW-1:0] max_exact,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     err_count,
  output logic                 overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic   clear;
  logic   accept;

  logic                 s1_valid;
  logic [PW:0]          s1_diff;
  logic signed [PW-1:0] s1_exact;

  logic [PW:0]    abs_diff;
  logic [ACC_W:0] sum_ext;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake and status flags decode only from the state register.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && in_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Stage 2 commits straight into the statistics, so an empty stage 1 means fully drained.
        if (!s1_valid) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          clear     = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1: one extra bit makes the signed difference exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_exact <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_diff  <= {prod_approx[PW-1], prod_approx} - {prod_exact[PW-1], prod_exact};
        s1_exact <= prod_exact;
      end
    end
  end

  assign abs_diff = s1_diff[PW] ? (~s1_diff + (PW+1)'(1)) : s1_diff;
  assign sum_ext  = {1'b0, sum_abs_err} + (ACC_W+1)'(abs_diff);

  // Stage 2: saturating statistics update; any clipped update latches overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_abs_err  <= '0;
      max_abs_err  <= '0;
      max_exact    <= '0;
      sample_count <= '0;
      err_count    <= '0;
      overflow     <= 1'b0;
    end else if (clear) begin
      sum_abs_err  <= '0;
      max_abs_err  <= '0;
      max_exact    <= '0;
      sample_count <= '0;
      err_count    <= '0;
      overflow     <= 1'b0;
    end else if (s1_valid) begin
      if (sum_ext[ACC_W]) begin
        sum_abs_err <= '1;
        overflow    <= 1'b1;
      end else begin
        sum_abs_err <= sum_ext[ACC_W-1:0];
      end
      if (abs_diff > max_abs_err) max_abs_err <= abs_diff;
      if (s1_exact > max_exact)   max_exact   <= s1_exact;
      if (&sample_count) overflow     <= 1'b1;
      else               sample_count <= sample_count + CNT_W'(1);
      if (s1_diff != '0) begin
        if (&err_count) overflow  <= 1'b1;
        else            err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule
